// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

    // Occupancy of a one-entry channel slot.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Width of the discarded-beat counter.
    localparam int DROP_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel. A load always
// wins over a drain, so load+drain in the same edge keeps the slot full
// with the new payload.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain_rdy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              free
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state: load takes priority; drain empties only a full slot.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = load_data;
        end else if (state_q == FULL && drain_rdy) begin
            state_d = EMPTY;
        end
    end

    // Slot registers; reset clears both occupancy and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    // Free this cycle if empty, or if the current beat leaves at this edge.
    assign free      = (state_q == EMPTY) || drain_rdy;

endmodule

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer: routes each input beat to one channel
// (or to all channels on broadcast) through per-channel one-entry slots.
// Beats addressed to a non-existent channel are accepted and dropped.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     err_sel,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    logic [NUM_CH-1:0]       free;
    logic [(1<<SEL_W)-1:0]   free_pad;
    logic [NUM_CH-1:0]       load;
    logic [31:0]             sel_ext;
    logic                    sel_ok;
    logic                    accept;
    logic                    drop;

    logic                    err_sel_q, err_sel_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    assign sel_ext = 32'(in_sel);
    assign sel_ok  = sel_ext < 32'(NUM_CH);

    // Pad the free vector to the full select range so any in_sel indexes safely.
    always_comb begin
        free_pad               = '0;
        free_pad[NUM_CH-1:0]   = free;
    end

    // Input handshake; in_ready never looks at in_valid.
    always_comb begin
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = free_pad[in_sel];
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid && in_ready;
    assign drop   = in_valid && !in_bcast && !sel_ok;

    // Per-channel load strobes from the accepted beat.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = accept && (in_bcast || (sel_ok && sel_ext == 32'(k)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_slot
            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (load[g]),
                .load_data (in_data),
                .drain_rdy (out_ready[g]),
                .out_valid (out_valid[g]),
                .out_data  (out_data[g*DATA_W +: DATA_W]),
                .free      (free[g])
            );
        end
    endgenerate

    // Error pulse and saturating drop count for discarded beats.
    always_comb begin
        err_sel_d  = drop;
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    // Error/drop status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_sel  = err_sel_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 Parameter NUM_CH, default 8, number of output channels (2..32, power of two not required).
REQ-003 Derived constant SEL_W = max(1, clog2(NUM_CH)), not overridable.
REQ-004 Port clk  input  1  single rising-edge clock for all state.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port in_valid  input  1  input beat present.
REQ-007 Port in_ready  output  1  block can accept the beat this cycle.
REQ-008 Port in_data  input  DATA_W  input payload.
REQ-009 Port in_sel  input  SEL_W  destination channel index.
REQ-010 Port in_bcast  input  1  1 = deliver the beat to all channels, in_sel ignored.
REQ-011 Port out_valid  output  NUM_CH  per-channel beat present.
REQ-012 Port out_ready  input  NUM_CH  per-channel consumer accept.
REQ-013 Port out_data  output  NUM_CH*DATA_W  channel k payload in bits [k*DATA_W +: DATA_W].
REQ-014 Port err_sel  output  1  one-cycle pulse: beat with in_sel >= NUM_CH was discarded.
REQ-015 Port drop_cnt  output  8  saturating count of discarded beats.

Function
REQ-016 Transfer in occurs when in_valid && in_ready at a clk edge; out transfer on channel k when out_valid[k] && out_ready[k].
REQ-017 Each channel has a one-entry slot with states EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-018 Slot k is "free" when EMPTY, or FULL with out_ready[k]=1 in the same cycle.
REQ-019 Unicast (in_bcast=0, in_sel<NUM_CH): in_ready = free(in_sel).
REQ-020 Broadcast (in_bcast=1): in_ready = AND of free(k) over all k; beat loads every slot in the same edge.
REQ-021 Invalid select (in_bcast=0, in_sel>=NUM_CH): in_ready=1; beat discarded, no slot changes.
REQ-022 Discarded beat: err_sel=1 the following cycle only; drop_cnt increments by 1, holds at 255.
REQ-023 Latency: a beat accepted at edge n shows out_valid/out_data at its slot(s) after edge n; zero bubbles under continuous out_ready.
REQ-024 Load and drain on the same slot in the same edge: slot stays FULL with the new payload.
REQ-025 Drain without load: slot goes EMPTY; out_data holds last value (don't-care, not checked).
REQ-026 While out_valid[k]=1 and out_ready[k]=0, out_data slice k and out_valid[k] are stable.
REQ-027 in_ready is combinational from in_valid-independent terms only (in_sel, in_bcast, out_valid, out_ready); it does not depend on in_valid.
REQ-028 Channels are independent: stalling channel j never blocks unicast traffic to channel k != j.

Reset
REQ-029 rst_n low asynchronously forces all slots EMPTY, out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
REQ-030 Reset mid-operation discards held beats; no beat is emitted after release until a new transfer in.
REQ-031 in_ready is computed from post-reset state (1 for any valid select) one cycle after release.

Structure
REQ-032 Package stream_demux_pkg holds the slot-state enum (EMPTY, FULL) and DROP_CNT_W = 8.
REQ-033 One sub-module demux_slot (one-entry register with load, drain, free output) is instantiated NUM_CH times via generate.

Verification
REQ-034 Unicast sweep: DATA_W=8, NUM_CH=8, all out_ready=1, send 0xA0+k to sel=k for k=0..7 back-to-back -> out_valid[k] one cycle later with 0xA0+k, in_ready constant 1.
REQ-035 Backpressure: out_ready[3]=0, send 0x11 then 0x22 to sel 3 -> 0x11 held stable, in_ready=0 for sel 3, in_ready=1 for sel 5 beat 0x55 delivered; raise out_ready[3] -> 0x22 accepted in the drain cycle (REQ-024).
REQ-036 Broadcast: all slots EMPTY, in_bcast=1, data 0x5A -> all eight out_valid=1 with 0x5A; then out_ready[6]=0 only, broadcast 0x66 -> in_ready=0 until out_ready[6]=1.
REQ-037 Invalid select: NUM_CH=6, in_sel=7, 300 beats -> no out_valid, err_sel pulses each following cycle, drop_cnt ends 255.
REQ-038 Async reset: three slots FULL with out_ready=0, pulse rst_n low between edges -> out_valid=0 immediately, drop_cnt=0, no stale beat after release.
